brick_damage_writer: RTL and testbench
======================================

Name: brick_damage_writer

Overview:
- Write-side producer of the per-hit `game_write` pulse and brick-memory updates.
- On each accepted ball/brick hit it does a read-modify-write of one brick's health in the brick RAM (synchronous, 1-cycle read latency).
- For every health point removed it emits exactly one `game_write` pulse toward the win-count logic.
- Sits between the collision detector (upstream, valid/ready) and the brick RAM plus win logic (downstream).

Parameters:
- GRID_COLS, 16, brick columns; col index width = clog2(GRID_COLS).
- GRID_ROWS, 8, brick rows; row index width = clog2(GRID_ROWS).
- HEALTH_W, 2, bits per brick health (0 = no brick, max 2^HEALTH_W-1).
- ADDR_W, 7, RAM address width; must satisfy 2^ADDR_W >= GRID_COLS*GRID_ROWS.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- hit_valid  in  1  collision detector presents a hit.
- hit_ready  out  1  block accepts hit when hit_valid && hit_ready.
- hit_col  in  clog2(GRID_COLS)  column of struck brick.
- hit_row  in  clog2(GRID_ROWS)  row of struck brick.
- mem_addr  out  ADDR_W  brick RAM address (read and write).
- mem_rd_data  in  HEALTH_W  RAM read data, valid 1 cycle after mem_addr.
- mem_wr_en  out  1  RAM write strobe, single cycle.
- mem_wr_data  out  HEALTH_W  new health value.
- game_write  out  1  one-cycle pulse per health point removed.
- brick_broken  out  1  one-cycle pulse when a health value reaches 0.
- busy  out  1  high whenever FSM is not IDLE.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high (clk, reset).
- Reset values:
  - FSM = IDLE.
  - mem_addr = 0, mem_wr_data = 0.
  - mem_wr_en, game_write, brick_broken, busy = 0.
  - hit_ready = 1 one cycle after reset deasserts.
- FSM states: IDLE, RD, WAIT, WR.
  - IDLE: hit_ready=1. On acceptance, register mem_addr = hit_row*GRID_COLS + hit_col, then go to RD.
  - RD: address held on RAM; go to WAIT.
  - WAIT: mem_rd_data valid; capture health h.
    - h == 0: empty cell; no write, no pulses; go to IDLE.
    - h != 0: mem_wr_data = h-1; go to WR.
  - WR: mem_wr_en=1 and game_write=1 in this cycle. brick_broken=1 in the same cycle if mem_wr_data==0. Go to IDLE.
- Latency: acceptance in cycle N gives mem_wr_en/game_write in cycle N+3. The next acceptance is possible at the earliest in N+4.
- Out-of-range hits (hit_col >= GRID_COLS or hit_row >= GRID_ROWS) are accepted and dropped: no RAM access, stay in IDLE.
- Arithmetic: address product computed at ADDR_W width, no truncation permitted. Health decrement never underflows, because the h==0 case is filtered in WAIT.
- Reset asserted mid-operation: immediate return to IDLE. A pending write is aborted (mem_wr_en never rises) and no pulse is emitted.
- hit_valid must stay asserted with stable col/row until accepted.

Optional Feature:
- Macro: BRICK_HIT_SKID_EN.
- Defined: adds a one-entry skid register.
  - hit_ready = !skid_full, so one hit can be accepted while busy.
  - The skidded hit is launched from IDLE on the cycle after WR/WAIT exit, taking priority over the live input.
  - Two hits to the same brick back-to-back read the already-written value, so RAM write-before-read ordering is preserved.
- Undefined: hit_ready = (state == IDLE); no skid storage.

Decomposition:
- Package brick_pkg holds:
  - GRID_COLS, GRID_ROWS, HEALTH_W, ADDR_W constants.
  - The state enum (IDLE/RD/WAIT/WR).
  - An address-compute function brick_addr(row, col).
- No sub-module in the base build. With BRICK_HIT_SKID_EN, the skid buffer is a natural sub-module: brick_hit_skid.

Test Plan:
- Single hit: RAM[5*16+3]=2; hit row=5, col=3 → mem_addr=83, mem_wr_data=1 in cycle N+3, one game_write, no brick_broken.
- Break brick: RAM[0]=1; hit (0,0) → mem_wr_data=0, game_write and brick_broken both high for one cycle.
- Empty cell: RAM[127]=0; hit (7,15) → no mem_wr_en, no pulses, hit_ready back high in N+3.
- Out of range: GRID_COLS=12, hit col=13 → accepted, no RAM activity, no pulses.
- Reset mid-op: assert reset in WAIT → mem_wr_en never asserts, all outputs 0, hit_ready=1 after release.
- Skid (BRICK_HIT_SKID_EN): RAM[10]=3; two hits to (0,10) one cycle apart → writes 2 then 1, two game_write pulses, second hit_ready low while the skid is full.

Source files
------------

// File: rtl/brick_pkg.sv
// Shared constants, FSM state type and address helper for the brick damage writer.
package brick_pkg;

  localparam int unsigned GRID_COLS = 16;
  localparam int unsigned GRID_ROWS = 8;
  localparam int unsigned HEALTH_W  = 2;
  localparam int unsigned ADDR_W    = 7;

  typedef enum logic [1:0] {
    IDLE,
    RD,
    WAIT,
    WR
  } brick_state_t;

  // Row-major brick index; callers size the grid so the result fits ADDR_W.
  function automatic int unsigned brick_addr(input int unsigned row,
                                             input int unsigned col,
                                             input int unsigned cols);
    return row * cols + col;
  endfunction

endpackage

// File: rtl/brick_hit_skid.sv
// One-entry holding register for a hit accepted while the writer is busy.
// Only built when BRICK_HIT_SKID_EN is defined.
`ifdef BRICK_HIT_SKID_EN
module brick_hit_skid #(
  parameter int unsigned COL_W = 4,
  parameter int unsigned ROW_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [COL_W-1:0] push_col,
  input  logic [ROW_W-1:0] push_row,
  input  logic             pop,
  output logic             full,
  output logic [COL_W-1:0] skid_col,
  output logic [ROW_W-1:0] skid_row
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full     <= 1'b0;
      skid_col <= '0;
      skid_row <= '0;
    end else if (push) begin
      full     <= 1'b1;
      skid_col <= push_col;
      skid_row <= push_row;
    end else if (pop) begin
      full     <= 1'b0;
    end
  end

endmodule
`endif

// File: rtl/brick_damage_writer.sv
// Read-modify-write of one brick's health per accepted hit, one game_write pulse per point removed.
// Optional one-entry hit skid buffer enabled by defining BRICK_HIT_SKID_EN.
module brick_damage_writer
  import brick_pkg::*;
#(
  parameter int unsigned GRID_COLS = brick_pkg::GRID_COLS,
  parameter int unsigned GRID_ROWS = brick_pkg::GRID_ROWS,
  parameter int unsigned HEALTH_W  = brick_pkg::HEALTH_W,
  parameter int unsigned ADDR_W    = brick_pkg::ADDR_W
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         hit_valid,
  output logic                         hit_ready,
  input  logic [$clog2(GRID_COLS)-1:0] hit_col,
  input  logic [$clog2(GRID_ROWS)-1:0] hit_row,
  output logic [ADDR_W-1:0]            mem_addr,
  input  logic [HEALTH_W-1:0]          mem_rd_data,
  output logic                         mem_wr_en,
  output logic [HEALTH_W-1:0]          mem_wr_data,
  output logic                         game_write,
  output logic                         brick_broken,
  output logic                         busy
);

  localparam int unsigned COL_W = $clog2(GRID_COLS);
  localparam int unsigned ROW_W = $clog2(GRID_ROWS);

  brick_state_t state, state_nxt;

  logic             ready_q;
  logic             launch_valid;
  logic [COL_W-1:0] launch_col;
  logic [ROW_W-1:0] launch_row;
  logic             launch;
  logic             in_range;

`ifdef BRICK_HIT_SKID_EN
  logic             skid_full;
  logic             skid_push;
  logic             skid_pop;
  logic [COL_W-1:0] skid_col;
  logic [ROW_W-1:0] skid_row;

  brick_hit_skid #(
    .COL_W(COL_W),
    .ROW_W(ROW_W)
  ) u_skid (
    .clk      (clk),
    .reset    (reset),
    .push     (skid_push),
    .push_col (hit_col),
    .push_row (hit_row),
    .pop      (skid_pop),
    .full     (skid_full),
    .skid_col (skid_col),
    .skid_row (skid_row)
  );

  // A held hit launches ahead of the live input; hits taken while busy go to the skid.
  always_comb begin
    hit_ready    = ready_q && !skid_full;
    launch_valid = skid_full || hit_valid;
    launch_col   = skid_full ? skid_col : hit_col;
    launch_row   = skid_full ? skid_row : hit_row;
    skid_push    = hit_valid && hit_ready && (state != IDLE);
    skid_pop     = launch && skid_full;
  end
`else
  always_comb begin
    hit_ready    = ready_q && (state == IDLE);
    launch_valid = hit_valid;
    launch_col   = hit_col;
    launch_row   = hit_row;
  end
`endif

  always_comb begin
    launch   = (state == IDLE) && ready_q && launch_valid;
    in_range = (32'(launch_col) < GRID_COLS) && (32'(launch_row) < GRID_ROWS);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    mem_wr_en    = 1'b0;
    game_write   = 1'b0;
    brick_broken = 1'b0;
    busy         = (state != IDLE);
    case (state)
      IDLE: begin
        if (launch && in_range) begin
          state_nxt = RD;
        end
      end
      RD: begin
        state_nxt = WAIT;
      end
      WAIT: begin
        state_nxt = (mem_rd_data == '0) ? IDLE : WR;
      end
      WR: begin
        mem_wr_en    = 1'b1;
        game_write   = 1'b1;
        brick_broken = (mem_wr_data == '0);
        state_nxt    = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ready_q     <= 1'b0;
      mem_addr    <= '0;
      mem_wr_data <= '0;
    end else begin
      ready_q <= 1'b1;
      if (launch && in_range) begin
        mem_addr <= ADDR_W'(brick_addr(32'(launch_row), 32'(launch_col), GRID_COLS));
      end
      if ((state == WAIT) && (mem_rd_data != '0)) begin
        mem_wr_data <= mem_rd_data - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_brick_damage_writer.sv
// Directed bench for brick_damage_writer: default 16x8 grid plus a 12-column instance for range checks.
module tb_brick_damage_writer;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic       hit_valid = 1'b0;
  logic [3:0] hit_col = '0;
  logic [2:0] hit_row = '0;
  logic       hit_ready;
  logic [6:0] mem_addr;
  logic [1:0] mem_rd_data;
  logic       mem_wr_en;
  logic [1:0] mem_wr_data;
  logic       game_write;
  logic       brick_broken;
  logic       busy;

  logic       oor_valid = 1'b0;
  logic [3:0] oor_col = '0;
  logic [2:0] oor_row = '0;
  logic       oor_ready;
  logic [6:0] oor_addr;
  logic [1:0] oor_rd_data = '0;
  logic       oor_wr_en;
  logic [1:0] oor_wr_data;
  logic       oor_gw;
  logic       oor_bb;
  logic       oor_busy;

  logic [1:0] ram [0:127];
  logic       load_en = 1'b0;
  logic [6:0] load_addr = '0;
  logic [1:0] load_data = '0;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  brick_damage_writer dut (
    .clk          (clk),
    .reset        (reset),
    .hit_valid    (hit_valid),
    .hit_ready    (hit_ready),
    .hit_col      (hit_col),
    .hit_row      (hit_row),
    .mem_addr     (mem_addr),
    .mem_rd_data  (mem_rd_data),
    .mem_wr_en    (mem_wr_en),
    .mem_wr_data  (mem_wr_data),
    .game_write   (game_write),
    .brick_broken (brick_broken),
    .busy         (busy)
  );

  brick_damage_writer #(
    .GRID_COLS (12),
    .GRID_ROWS (8),
    .HEALTH_W  (2),
    .ADDR_W    (7)
  ) u_oor (
    .clk          (clk),
    .reset        (reset),
    .hit_valid    (oor_valid),
    .hit_ready    (oor_ready),
    .hit_col      (oor_col),
    .hit_row      (oor_row),
    .mem_addr     (oor_addr),
    .mem_rd_data  (oor_rd_data),
    .mem_wr_en    (oor_wr_en),
    .mem_wr_data  (oor_wr_data),
    .game_write   (oor_gw),
    .brick_broken (oor_bb),
    .busy         (oor_busy)
  );

  // Synchronous brick RAM, read-first, with a bench-side preload port.
  always @(posedge clk) begin
    mem_rd_data <= ram[mem_addr];
    if (load_en) ram[load_addr] <= load_data;
    else if (mem_wr_en) ram[mem_addr] <= mem_wr_data;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [6:0] addr, input logic [1:0] data);
    load_en   = 1'b1;
    load_addr = addr;
    load_data = data;
    tick();
    load_en   = 1'b0;
  endtask

  // Present one hit, then watch six cycles after acceptance.
  task automatic run_hit(input string tag, input logic [2:0] row, input logic [3:0] col,
                         input int exp_addr, input int exp_write, input int exp_data,
                         input int exp_broken, input int exp_ready_cyc);
    int wr_cnt  = 0;
    int gw_cnt  = 0;
    int bb_cnt  = 0;
    int wr_cyc  = -1;
    int rdy_cyc = -1;
    int wr_val  = -1;
    hit_row   = row;
    hit_col   = col;
    hit_valid = 1'b1;
    check({tag, ".ready_in"}, 32'(hit_ready), 1);
    tick();
    hit_valid = 1'b0;
    check({tag, ".addr"}, 32'(mem_addr), exp_addr);
    for (int c = 1; c <= 6; c++) begin
      if (mem_wr_en) begin
        wr_cnt++;
        wr_cyc = c;
        wr_val = int'(mem_wr_data);
      end
      if (game_write) gw_cnt++;
      if (brick_broken) bb_cnt++;
      if (hit_ready && rdy_cyc < 0) rdy_cyc = c;
      tick();
    end
    check({tag, ".writes"}, wr_cnt, exp_write);
    check({tag, ".game_write"}, gw_cnt, exp_write);
    check({tag, ".broken"}, bb_cnt, exp_broken);
    check({tag, ".ready_cyc"}, rdy_cyc, exp_ready_cyc);
    if (exp_write != 0) begin
      check({tag, ".wr_cyc"}, wr_cyc, 3);
      check({tag, ".wr_data"}, wr_val, exp_data);
    end
  endtask

  initial begin
    int cnt_a;
    int cnt_b;
    int cnt_c;

    // Reset values
    reset = 1'b1;
    tick();
    check("rst.hit_ready", 32'(hit_ready), 0);
    check("rst.busy", 32'(busy), 0);
    check("rst.mem_wr_en", 32'(mem_wr_en), 0);
    check("rst.game_write", 32'(game_write), 0);
    check("rst.brick_broken", 32'(brick_broken), 0);
    check("rst.mem_addr", 32'(mem_addr), 0);
    check("rst.mem_wr_data", 32'(mem_wr_data), 0);
    tick();
    reset = 1'b0;
    #1;
    check("rel.ready_early", 32'(hit_ready), 0);
    tick();
    check("rel.ready", 32'(hit_ready), 1);
    check("rel.oor_ready", 32'(oor_ready), 1);

    load(7'd83, 2'd2);
    load(7'd0, 2'd1);
    load(7'd127, 2'd0);
    load(7'd50, 2'd3);
    load(7'd17, 2'd2);
    load(7'd10, 2'd3);

    run_hit("single", 3'd5, 4'd3, 83, 1, 1, 0, 4);
    run_hit("break", 3'd0, 4'd0, 0, 1, 0, 1, 4);
    run_hit("empty", 3'd7, 4'd15, 127, 0, 0, 0, 3);
    run_hit("max", 3'd3, 4'd2, 50, 1, 2, 0, 4);
    run_hit("again", 3'd5, 4'd3, 83, 1, 0, 1, 4);
    run_hit("dead", 3'd0, 4'd0, 0, 0, 0, 0, 3);
    check("ram83", 32'(ram[83]), 0);
    check("ram50", 32'(ram[50]), 2);

    // Reset while in WAIT aborts the pending write
    hit_row   = 3'd1;
    hit_col   = 4'd1;
    hit_valid = 1'b1;
    tick();
    hit_valid = 1'b0;
    tick();
    check("midrst.busy_pre", 32'(busy), 1);
    reset = 1'b1;
    #1;
    check("midrst.busy", 32'(busy), 0);
    check("midrst.mem_wr_en", 32'(mem_wr_en), 0);
    check("midrst.game_write", 32'(game_write), 0);
    check("midrst.mem_addr", 32'(mem_addr), 0);
    check("midrst.hit_ready", 32'(hit_ready), 0);
    cnt_a = 0;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (mem_wr_en || game_write || brick_broken) cnt_a++;
    end
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (mem_wr_en || game_write || brick_broken) cnt_a++;
    end
    check("midrst.pulses", cnt_a, 0);
    check("midrst.ready_after", 32'(hit_ready), 1);
    check("midrst.ram17", 32'(ram[17]), 2);

    // Column past a 12-wide grid is accepted and dropped
    oor_row   = 3'd2;
    oor_col   = 4'd13;
    oor_valid = 1'b1;
    check("oor.ready_in", 32'(oor_ready), 1);
    tick();
    oor_valid = 1'b0;
    cnt_a = 0;
    for (int c = 0; c < 4; c++) begin
      if (oor_busy || oor_wr_en || oor_gw || oor_bb || !oor_ready) cnt_a++;
      tick();
    end
    check("oor.activity", cnt_a, 0);

    // Last in-range column of the 12-wide grid: 2*12+11
    oor_col   = 4'd11;
    oor_valid = 1'b1;
    tick();
    oor_valid = 1'b0;
    check("oor.edge_addr", 32'(oor_addr), 35);
    check("oor.edge_busy", 32'(oor_busy), 1);
    cnt_a = 0;
    for (int c = 0; c < 4; c++) begin
      if (oor_wr_en || oor_gw) cnt_a++;
      tick();
    end
    check("oor.edge_empty", cnt_a, 0);
    check("oor.edge_ready", 32'(oor_ready), 1);

`ifdef BRICK_HIT_SKID_EN
    // Two hits to the same brick one cycle apart
    hit_row   = 3'd0;
    hit_col   = 4'd10;
    hit_valid = 1'b1;
    tick();
    check("skid.ready_busy", 32'(hit_ready), 1);
    tick();
    hit_valid = 1'b0;
    cnt_a = 0;
    cnt_b = 0;
    cnt_c = 0;
    for (int c = 2; c <= 10; c++) begin
      if (mem_wr_en) begin
        cnt_a++;
        if (cnt_a == 1) begin
          check("skid.wr1_cyc", c, 3);
          check("skid.wr1_data", 32'(mem_wr_data), 2);
        end else begin
          check("skid.wr2_cyc", c, 7);
          check("skid.wr2_data", 32'(mem_wr_data), 1);
        end
      end
      if (game_write) cnt_b++;
      if (!hit_ready && c <= 5) cnt_c++;
      tick();
    end
    check("skid.writes", cnt_a, 2);
    check("skid.game_write", cnt_b, 2);
    check("skid.ready_low", cnt_c, 3);
    check("skid.ram10", 32'(ram[10]), 1);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
